mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Accepts an instruction whose data-SRAM address handshake has already completed (or which never issued one), then waits for the matching data response.
- Extracts and extends load data, and presents the final result to writeback.
- Tracks responses belonging to flushed instructions and discards them silently.

---
 rtl/mem_stage_if.sv | 91 +++++++++
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and payload bundle between exe, data SRAM, mem_stage and wb.
// MEM_FWD_EN adds the mem-stage bypass signals.
interface mem_stage_if;
  logic        exe_to_mem_valid;
  logic        mem_allowin;
  logic        exe_req_issued;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic [4:0]  exe_dest;
  logic        exe_gr_we;
  logic        exe_res_from_mem;
  logic        exe_op_b;
  logic        exe_op_h;
  logic        exe_op_unsigned;
  logic        exe_ex;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_final_result;
  logic [4:0]  mem_dest;
  logic        mem_gr_we;
  logic        mem_ex;
  logic        mem_load_pending;
  logic        exec_flush;
`ifdef MEM_FWD_EN
  logic [31:0] mem_fwd_data;
  logic        mem_fwd_valid;
`endif

  modport master (
    output exe_to_mem_valid,
    output exe_req_issued,
    output exe_pc,
    output exe_result,
    output exe_dest,
    output exe_gr_we,
    output exe_res_from_mem,
    output exe_op_b,
    output exe_op_h,
    output exe_op_unsigned,
    output exe_ex,
    output data_sram_data_ok,
    output data_sram_rdata,
    output wb_allowin,
    output exec_flush,
    input  mem_allowin,
    input  mem_to_wb_valid,
    input  mem_pc,
    input  mem_final_result,
    input  mem_dest,
    input  mem_gr_we,
    input  mem_ex,
`ifdef MEM_FWD_EN
    input  mem_fwd_data,
    input  mem_fwd_valid,
`endif
    input  mem_load_pending
  );

  modport slave (
    input  exe_to_mem_valid,
    input  exe_req_issued,
    input  exe_pc,
    input  exe_result,
    input  exe_dest,
    input  exe_gr_we,
    input  exe_res_from_mem,
    input  exe_op_b,
    input  exe_op_h,
    input  exe_op_unsigned,
    input  exe_ex,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    input  wb_allowin,
    input  exec_flush,
    output mem_allowin,
    output mem_to_wb_valid,
    output mem_pc,
    output mem_final_result,
    output mem_dest,
    output mem_gr_we,
    output mem_ex,
`ifdef MEM_FWD_EN
    output mem_fwd_data,
    output mem_fwd_valid,
`endif
    output mem_load_pending
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: waits for data response, extends load data, drops flushed responses.
// Optional MEM_FWD_EN exposes mem_fwd_data / mem_fwd_valid for bypass.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);

  localparam logic [DISCARD_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_mem;
    logic        op_b;
    logic        op_h;
    logic        op_unsigned;
    logic        ex;
  } mem_pl_t;

  mem_pl_t              pl;
  logic                 mem_valid;
  logic                 wait_data;
  logic                 rdata_buf_valid;
  logic [31:0]          rdata_buf;
  logic [DISCARD_W-1:0] discard_cnt;
  logic [DISCARD_W-1:0] discard_nxt;
  logic [DISCARD_W+1:0] cnt_sum;
  logic                 discard_ovf;

  logic cnt_zero;
  logic rsp_own;
  logic rsp_drop;
  logic rsp_take;
  logic ready_go;
  logic allowin;
  logic latch;
  logic flush_wait;
  logic flush_req;

  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] final_result;
  logic        gr_we;

  assign cnt_zero = discard_cnt == '0;
  assign rsp_own  = bus.data_sram_data_ok & cnt_zero;
  assign rsp_drop = bus.data_sram_data_ok & ~cnt_zero;
  assign rsp_take = rsp_own & wait_data;

  assign ready_go = ~wait_data | rdata_buf_valid | rsp_own;
  assign allowin  = ~mem_valid | (ready_go & bus.wb_allowin);
  assign latch    = allowin & bus.exe_to_mem_valid;

  // Both a stranded waiting load and an upstream request killed
  // by the flush still owe a response that must be swallowed.
  assign flush_wait = bus.exec_flush & mem_valid
                    & wait_data & ~rsp_own;
  assign flush_req  = bus.exec_flush & bus.exe_to_mem_valid
                    & bus.exe_req_issued;

  always_comb begin
    cnt_sum = {2'b00, discard_cnt}
            + {{(DISCARD_W+1){1'b0}}, flush_wait}
            + {{(DISCARD_W+1){1'b0}}, flush_req}
            - {{(DISCARD_W+1){1'b0}}, rsp_drop};
    discard_ovf = cnt_sum > {2'b00, CNT_MAX};
    discard_nxt = discard_ovf ? CNT_MAX
                              : cnt_sum[DISCARD_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else begin
      discard_cnt <= discard_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
    end else if (bus.exec_flush) begin
      mem_valid <= 1'b0;
    end else if (allowin) begin
      mem_valid <= bus.exe_to_mem_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_data <= 1'b0;
    end else if (bus.exec_flush) begin
      wait_data <= 1'b0;
    end else if (latch) begin
      wait_data <= bus.exe_req_issued & ~bus.exe_ex;
    end else if (rsp_take) begin
      wait_data <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
    end else if (bus.exec_flush || latch) begin
      rdata_buf_valid <= 1'b0;
    end else if (rsp_take && !bus.wb_allowin) begin
      rdata_buf_valid <= 1'b1;
      rdata_buf       <= bus.data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pl <= '0;
    end else if (latch) begin
      pl.pc           <= bus.exe_pc;
      pl.result       <= bus.exe_result;
      pl.dest         <= bus.exe_dest;
      pl.gr_we        <= bus.exe_gr_we;
      pl.res_from_mem <= bus.exe_res_from_mem;
      pl.op_b         <= bus.exe_op_b;
      pl.op_h         <= bus.exe_op_h;
      pl.op_unsigned  <= bus.exe_op_unsigned;
      pl.ex           <= bus.exe_ex;
    end
  end

  always_comb begin
    ld_word = rdata_buf_valid ? rdata_buf
                              : bus.data_sram_rdata;
    ld_byte = ld_word[7:0];
    unique case (pl.result[1:0])
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = pl.result[1] ? ld_word[31:16]
                           : ld_word[15:0];
    ld_ext = ld_word;
    unique case (1'b1)
      pl.op_b: ld_ext = {{24{~pl.op_unsigned & ld_byte[7]}},
                         ld_byte};
      pl.op_h: ld_ext = {{16{~pl.op_unsigned & ld_half[15]}},
                         ld_half};
      default: ld_ext = ld_word;
    endcase
  end

  assign final_result = pl.res_from_mem ? ld_ext : pl.result;
  assign gr_we        = pl.gr_we & ~pl.ex;

  assign bus.mem_allowin      = allowin;
  assign bus.mem_to_wb_valid  = mem_valid & ready_go
                              & ~bus.exec_flush;
  assign bus.mem_pc           = pl.pc;
  assign bus.mem_final_result = final_result;
  assign bus.mem_dest         = (mem_valid & gr_we) ? pl.dest
                                                    : 5'd0;
  assign bus.mem_gr_we        = gr_we;
  assign bus.mem_ex           = pl.ex;
  assign bus.mem_load_pending = mem_valid & pl.res_from_mem
                              & ~ready_go;

`ifdef MEM_FWD_EN
  assign bus.mem_fwd_data  = final_result;
  assign bus.mem_fwd_valid = mem_valid & gr_we & ready_go;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: loads, buffering, flush discard, reset.
// Builds with or without MEM_FWD_EN.
module tb_mem_stage;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
  } exp_t;

  exp_t q[$];

  mem_stage_if bus ();

  mem_stage #(.DISCARD_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.mem_to_wb_valid && bus.wb_allowin) begin
      chk("sb_avail", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        chk("sb_pc", bus.mem_pc, q[0].pc);
        chk("sb_res", bus.mem_final_result, q[0].res);
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && dut.discard_ovf)
      chk("discard_ovf", {31'd0, dut.discard_ovf}, 32'd0);
  end

  task automatic issue(input logic [31:0] pc,
                       input logic [31:0] res,
                       input logic [4:0]  dest,
                       input logic        ld,
                       input logic        b,
                       input logic        h,
                       input logic        u,
                       input logic        req,
                       input logic        ex,
                       input logic [31:0] exp,
                       input bit          track);
    @(posedge clk); #1;
    bus.exe_to_mem_valid  = 1'b1;
    bus.exe_req_issued    = req;
    bus.exe_pc            = pc;
    bus.exe_result        = res;
    bus.exe_dest          = dest;
    bus.exe_gr_we         = 1'b1;
    bus.exe_res_from_mem  = ld;
    bus.exe_op_b          = b;
    bus.exe_op_h          = h;
    bus.exe_op_unsigned   = u;
    bus.exe_ex            = ex;
    bus.data_sram_data_ok = 1'b0;
    bus.exec_flush        = 1'b0;
    bus.wb_allowin        = 1'b1;
    @(negedge clk);
    chk("allowin", {31'd0, bus.mem_allowin}, 32'd1);
    if (track) q.push_back('{pc, exp});
  endtask

  task automatic cyc(input logic        ok,
                     input logic [31:0] rd,
                     input logic        fl,
                     input logic        wb);
    @(posedge clk); #1;
    bus.exe_to_mem_valid  = 1'b0;
    bus.exe_req_issued    = 1'b0;
    bus.data_sram_data_ok = ok;
    bus.data_sram_rdata   = rd;
    bus.exec_flush        = fl;
    bus.wb_allowin        = wb;
    @(negedge clk);
  endtask

  logic [1:0]  t_a[4]  = '{2'd1, 2'd0, 2'd2, 2'd0};
  logic        t_b[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic        t_h[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic        t_u[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_rd[4] = '{32'h1234_5678, 32'h1234_F00D,
                           32'h00AB_0000, 32'hCAFE_F00D};
  logic [31:0] t_ex[4] = '{32'h0000_0056, 32'hFFFF_F00D,
                           32'h0000_00AB, 32'hCAFE_F00D};

  initial begin
    bus.exe_to_mem_valid  = 1'b0;
    bus.exe_req_issued    = 1'b0;
    bus.exe_pc            = '0;
    bus.exe_result        = '0;
    bus.exe_dest          = '0;
    bus.exe_gr_we         = 1'b0;
    bus.exe_res_from_mem  = 1'b0;
    bus.exe_op_b          = 1'b0;
    bus.exe_op_h          = 1'b0;
    bus.exe_op_unsigned   = 1'b0;
    bus.exe_ex            = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = '0;
    bus.wb_allowin        = 1'b1;
    bus.exec_flush        = 1'b0;
    #12;
    chk("rst_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    chk("rst_allowin", {31'd0, bus.mem_allowin}, 32'd1);
    chk("rst_pending", {31'd0, bus.mem_load_pending}, 32'd0);
    chk("rst_dest", {27'd0, bus.mem_dest}, 32'd0);
    chk("rst_gr_we", {31'd0, bus.mem_gr_we}, 32'd0);
    chk("rst_ex", {31'd0, bus.mem_ex}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // add, passes straight through
    issue(32'h1000, 32'h1234, 5'd5, 0, 0, 0, 0, 0, 0,
          32'h1234, 1);
    cyc(0, 32'h0, 0, 1);
    chk("add_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
    chk("add_pending", {31'd0, bus.mem_load_pending}, 32'd0);
    chk("add_dest", {27'd0, bus.mem_dest}, 32'd5);
`ifdef MEM_FWD_EN
    chk("fwd_valid", {31'd0, bus.mem_fwd_valid}, 32'd1);
    chk("fwd_data", bus.mem_fwd_data, 32'h1234);
`endif

    // excepting instruction: write enable masked
    issue(32'h1004, 32'h99, 5'd7, 0, 0, 0, 0, 0, 1,
          32'h99, 1);
    cyc(0, 32'h0, 0, 1);
    chk("ex_flag", {31'd0, bus.mem_ex}, 32'd1);
    chk("ex_gr_we", {31'd0, bus.mem_gr_we}, 32'd0);
    chk("ex_dest", {27'd0, bus.mem_dest}, 32'd0);

    // ld.b at offset 3
    issue(32'h1008, 32'h2003, 5'd6, 1, 1, 0, 0, 1, 0,
          32'hFFFF_FF80, 1);
    cyc(0, 32'h0, 0, 1);
    chk("ldb_pending", {31'd0, bus.mem_load_pending}, 32'd1);
    chk("ldb_wait", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    cyc(1, 32'h80FF_1234, 0, 1);
    chk("ldb_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
    cyc(0, 32'h0, 0, 1);
    chk("ldb_pulse", {31'd0, bus.mem_to_wb_valid}, 32'd0);

    // ld.hu, writeback stalled, data buffered
    issue(32'h100C, 32'h2002, 5'd8, 1, 0, 1, 1, 1, 0,
          32'h0000_8001, 1);
    cyc(1, 32'h8001_0000, 0, 0);
    chk("ldhu_v0", {31'd0, bus.mem_to_wb_valid}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      cyc(0, 32'hFFFF_FFFF, 0, 0);
      chk("ldhu_hold", {31'd0, bus.mem_to_wb_valid}, 32'd1);
      chk("ldhu_buf", bus.mem_final_result, 32'h0000_8001);
    end
    cyc(0, 32'hFFFF_FFFF, 0, 1);
    cyc(0, 32'h0, 0, 1);
    chk("ldhu_done", {31'd0, bus.mem_to_wb_valid}, 32'd0);

    // extension table
    for (int i = 0; i < 4; i++) begin
      issue(32'h2000 + 32'(i * 4), {30'h800, t_a[i]}, 5'd9,
            1, t_b[i], t_h[i], t_u[i], 1, 0, t_ex[i], 1);
      cyc(1, t_rd[i], 0, 1);
      chk("tbl_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
    end

    // flush mid-wait, stale response dropped
    issue(32'h3000, 32'h4000, 5'd10, 1, 0, 0, 0, 1, 0,
          32'h0, 0);
    cyc(0, 32'h0, 1, 1);
    chk("fl_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    issue(32'h3004, 32'h4004, 5'd11, 1, 0, 0, 0, 1, 0,
          32'h0000_0042, 1);
    cyc(1, 32'hDEAD_BEEF, 0, 1);
    chk("fl_drop", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    chk("fl_pending", {31'd0, bus.mem_load_pending}, 32'd1);
    cyc(1, 32'h0000_0042, 0, 1);
    chk("fl_done", {31'd0, bus.mem_to_wb_valid}, 32'd1);

    // flush with waiting load and in-flight request: two drops
    issue(32'h3100, 32'h4100, 5'd12, 1, 0, 0, 0, 1, 0,
          32'h0, 0);
    @(posedge clk); #1;
    bus.exe_to_mem_valid = 1'b1;
    bus.exe_req_issued   = 1'b1;
    bus.exec_flush       = 1'b1;
    @(negedge clk);
    chk("fl2_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h1111_0000 + 32'(i), 0, 1);
      chk("fl2_drop", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    end
    issue(32'h3104, 32'h4104, 5'd13, 1, 0, 0, 0, 1, 0,
          32'h0000_0055, 1);
    cyc(1, 32'h0000_0055, 0, 1);
    chk("fl2_done", {31'd0, bus.mem_to_wb_valid}, 32'd1);

    // reset while waiting with one pending discard
    issue(32'h3200, 32'h4200, 5'd14, 1, 0, 0, 0, 1, 0,
          32'h0, 0);
    cyc(0, 32'h0, 1, 1);
    issue(32'h3204, 32'h4204, 5'd15, 1, 0, 0, 0, 1, 0,
          32'h0, 0);
    @(posedge clk); #1;
    bus.exe_to_mem_valid = 1'b0;
    bus.exe_req_issued   = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rr_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
    chk("rr_allowin", {31'd0, bus.mem_allowin}, 32'd1);
    chk("rr_pending", {31'd0, bus.mem_load_pending}, 32'd0);
    q.delete();
    @(posedge clk); #1 resetn = 1'b1;
    issue(32'h3300, 32'h4300, 5'd16, 1, 0, 0, 0, 1, 0,
          32'h0000_0077, 1);
    cyc(1, 32'h0000_0077, 0, 1);
    chk("rr_done", {31'd0, bus.mem_to_wb_valid}, 32'd1);
    cyc(0, 32'h0, 0, 1);

    chk("sb_drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
